// File: rtl/bus_port_adapter.sv
// bus_port_adapter: per-port TX/RX FIFO endpoint between a device and the bs_gnrtr_n_rbtr bus
module bus_port_adapter #(
  parameter int pckg_sz = 16,
  parameter int deep_fifo = 8,
  parameter logic [7:0] port_id = 8'd0,
  parameter logic [7:0] bcast_id = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dev_tx_valid,
  input  logic [pckg_sz-1:0]           dev_tx_data,
  output logic                         dev_tx_ready,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  output logic                         dev_rx_valid,
  output logic [pckg_sz-1:0]           dev_rx_data,
  input  logic                         dev_rx_ready,
  output logic [$clog2(deep_fifo):0]   tx_count,
  output logic [$clog2(deep_fifo):0]   rx_count,
  output logic [7:0]                   drop_cnt,
  output logic [1:0]                   err
);
  localparam int aw = $clog2(deep_fifo);
  localparam logic [aw:0] full_cnt = (aw+1)'(deep_fifo);
  logic [pckg_sz-1:0] tx_mem [deep_fifo];
  logic [pckg_sz-1:0] rx_mem [deep_fifo];
  logic [aw:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_we, tx_re, rx_we, rx_re, rx_hit;
  logic [7:0] rx_id;
  assign tx_count = tx_wp - tx_rp;
  assign rx_count = rx_wp - rx_rp;
  assign pndng = tx_wp != tx_rp;
  assign dev_rx_valid = rx_wp != rx_rp;
  assign dev_tx_ready = tx_count != full_cnt;
  assign rx_id = D_push[pckg_sz-1 -: 8];
  assign rx_hit = rx_id == port_id || rx_id == bcast_id;
  assign tx_we = dev_tx_valid && dev_tx_ready;
  assign tx_re = pop && pndng;
  assign rx_we = push && rx_hit && rx_count != full_cnt;
  assign rx_re = dev_rx_ready && dev_rx_valid;
  // Heads read as zero when empty so the outputs follow reset without clearing storage
  assign D_pop = pndng ? tx_mem[tx_rp[aw-1:0]] : '0;
  assign dev_rx_data = dev_rx_valid ? rx_mem[rx_rp[aw-1:0]] : '0;
  // Packet storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_wp[aw-1:0]] <= dev_tx_data;
    if (rx_we) rx_mem[rx_wp[aw-1:0]] <= D_push;
  end
  // Pointers, saturating drop counter and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      drop_cnt <= '0;
      err <= '0;
    end else begin
      tx_wp <= tx_wp + (aw+1)'(tx_we);
      tx_rp <= tx_rp + (aw+1)'(tx_re);
      rx_wp <= rx_wp + (aw+1)'(rx_we);
      rx_rp <= rx_rp + (aw+1)'(rx_re);
      drop_cnt <= drop_cnt + 8'(push && !rx_we && drop_cnt != 8'hFF);
      err <= err | {push && !rx_hit, pop && !pndng};
    end
  end
endmodule
